mem_arbiter: RTL and testbench

Two-port arbiter that shares the single four-bank main memory between the instruction-cache controller (port 0) and the data-cache controller (port 1). It passes the granted port's read/write straight through to memory in the same cycle. It holds ownership for a whole locked miss sequence (write-back plus line fill) so bursts never interleave. It routes each read's return data, RD_LATENCY cycles later, back to the port that issued the read.

---
 rtl/mem_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_arbiter.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one main memory between the I-cache (port 0) and D-cache (port 1).
// Zero-cycle pass-through arbitration, locked ownership for miss bursts, read-return routing.
module mem_arbiter #(
  parameter int unsigned RD_LATENCY = 2,
  parameter int unsigned DATA_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_0,
  input  logic              wr_0,
  input  logic              lock_0,
  input  logic [DATA_W-1:0] addr_0,
  input  logic [DATA_W-1:0] data_in_0,
  input  logic              rd_1,
  input  logic              wr_1,
  input  logic              lock_1,
  input  logic [DATA_W-1:0] addr_1,
  input  logic [DATA_W-1:0] data_in_1,
  output logic              stall_0,
  output logic              stall_1,
  output logic              grant_0,
  output logic              grant_1,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid_0,
  output logic              data_valid_1,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_data_out,
  input  logic              mem_stall,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  state_e                state_q, state_d, state_eff;
  logic                  prio_q, prio_d, prio_eff;
  logic [RD_LATENCY-1:0] pvld_q, pvld_d;
  logic [RD_LATENCY-1:0] pid_q, pid_d;
  logic                  req_0, req_1;
  logic                  gnt_0, gnt_1;
  logic                  push;

  assign req_0 = rd_0 | wr_0 | lock_0;
  assign req_1 = rd_1 | wr_1 | lock_1;

  // Grant selection; a reset cycle arbitrates as IDLE with port 0 preferred.
  always_comb begin : arb_select
    gnt_0     = 1'b0;
    gnt_1     = 1'b0;
    state_eff = rst ? IDLE : state_q;
    prio_eff  = rst ? 1'b0 : prio_q;
    case (state_eff)
      OWN0:    gnt_0 = 1'b1;
      OWN1:    gnt_1 = 1'b1;
      default: begin
        if (req_0 && req_1) begin
          gnt_0 = ~prio_eff;
          gnt_1 = prio_eff;
        end else begin
          gnt_0 = req_0;
          gnt_1 = req_1;
        end
      end
    endcase
  end

  // Ownership and priority; a stalled owner keeps the bus until its last access is taken.
  always_comb begin : next_state
    state_d = state_q;
    prio_d  = prio_q;
    case (state_q)
      IDLE: begin
        if (gnt_0) begin
          if (lock_0) state_d = OWN0;
          else        prio_d  = 1'b1;
        end else if (gnt_1) begin
          if (lock_1) state_d = OWN1;
          else        prio_d  = 1'b0;
        end
      end
      OWN0: begin
        if (!mem_stall && !lock_0) begin
          state_d = IDLE;
          prio_d  = 1'b1;
        end
      end
      OWN1: begin
        if (!mem_stall && !lock_1) begin
          state_d = IDLE;
          prio_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Return pipeline: one {valid, port} entry per cycle, only accepted reads are valid.
  always_comb begin : ret_pipe
    push   = ((gnt_0 & rd_0) | (gnt_1 & rd_1)) & ~mem_stall;
    pvld_d = RD_LATENCY'({pvld_q, push});
    pid_d  = RD_LATENCY'({pid_q, gnt_1});
  end

  always_comb begin : outputs
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = '0;
    mem_data_in  = '0;
    err          = 1'b0;
    if (gnt_0) begin
      mem_rd      = rd_0;
      mem_wr      = wr_0;
      mem_addr    = addr_0;
      mem_data_in = data_in_0;
      err         = rd_0 & wr_0;
    end else if (gnt_1) begin
      mem_rd      = rd_1;
      mem_wr      = wr_1;
      mem_addr    = addr_1;
      mem_data_in = data_in_1;
      err         = rd_1 & wr_1;
    end
    grant_0      = gnt_0;
    grant_1      = gnt_1;
    stall_0      = req_0 & (~gnt_0 | mem_stall);
    stall_1      = req_1 & (~gnt_1 | mem_stall);
    // In-flight returns are discarded by reset, including the reset cycle itself.
    data_valid_0 = ~rst & pvld_q[RD_LATENCY-1] & ~pid_q[RD_LATENCY-1];
    data_valid_1 = ~rst & pvld_q[RD_LATENCY-1] &  pid_q[RD_LATENCY-1];
    data_out     = mem_data_out;
  end

  always_ff @(posedge clk) begin : state_reg
    if (rst) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      pvld_q  <= '0;
      pid_q   <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      pvld_q  <= pvld_d;
      pid_q   <= pid_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level ownership/return model.
module tb_mem_arbiter;
  localparam int unsigned L = 2;
  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         rd_0, wr_0, lock_0, rd_1, wr_1, lock_1;
  logic [W-1:0] addr_0, data_in_0, addr_1, data_in_1;
  logic         stall_0, stall_1, grant_0, grant_1;
  logic [W-1:0] data_out;
  logic         data_valid_0, data_valid_1;
  logic [W-1:0] mem_addr, mem_data_in;
  logic         mem_rd, mem_wr;
  logic [W-1:0] mem_data_out;
  logic         mem_stall;
  logic         err;

  logic [3:0] gs;
  logic [1:0] dv;
  assign gs = {grant_0, grant_1, stall_0, stall_1};
  assign dv = {data_valid_0, data_valid_1};

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Reference model: current owner (-1 = none), priority port, and expected returns by cycle.
  int m_owner = -1;
  bit m_prio  = 1'b0;
  int ret_q[int];

  always #5 clk = ~clk;

  mem_arbiter #(.RD_LATENCY(L), .DATA_W(W)) dut (
    .clk(clk), .rst(rst),
    .rd_0(rd_0), .wr_0(wr_0), .lock_0(lock_0), .addr_0(addr_0), .data_in_0(data_in_0),
    .rd_1(rd_1), .wr_1(wr_1), .lock_1(lock_1), .addr_1(addr_1), .data_in_1(data_in_1),
    .stall_0(stall_0), .stall_1(stall_1), .grant_0(grant_0), .grant_1(grant_1),
    .data_out(data_out), .data_valid_0(data_valid_0), .data_valid_1(data_valid_1),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_data_out(mem_data_out), .mem_stall(mem_stall), .err(err)
  );

  function automatic bit req(int p);
    return (p == 0) ? (rd_0 | wr_0 | lock_0) : (rd_1 | wr_1 | lock_1);
  endfunction

  function automatic int model_grant();
    int own = rst ? -1 : m_owner;
    bit pr  = rst ? 1'b0 : m_prio;
    if (own >= 0) return own;
    if (req(0) && req(1)) return int'(pr);
    if (req(0)) return 0;
    if (req(1)) return 1;
    return -1;
  endfunction

  task automatic model_step();
    int g;
    bit rd_g, lock_g;
    g = model_grant();
    if (ret_q.exists(cyc)) ret_q.delete(cyc);
    if (rst) begin
      m_owner = -1;
      m_prio  = 1'b0;
      ret_q.delete();
      return;
    end
    if (g < 0) return;
    rd_g   = (g == 0) ? rd_0 : rd_1;
    lock_g = (g == 0) ? lock_0 : lock_1;
    if (rd_g && !mem_stall) ret_q[cyc + int'(L)] = g;
    if (m_owner < 0) begin
      if (lock_g) m_owner = g;
      else        m_prio  = (g == 0);
    end else if (!mem_stall && !lock_g) begin
      m_owner = -1;
      m_prio  = (g == 0);
    end
  endtask

  task automatic next_cycle();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    mem_data_out = W'($urandom);
  endtask

  task automatic idle_in();
    rst = 1'b0; mem_stall = 1'b0;
    rd_0 = 1'b0; wr_0 = 1'b0; lock_0 = 1'b0; addr_0 = '0; data_in_0 = '0;
    rd_1 = 1'b0; wr_1 = 1'b0; lock_1 = 1'b0; addr_1 = '0; data_in_1 = '0;
  endtask

  task automatic test_reset();
    idle_in();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (gs !== 4'b0000) begin errors++; $display("FAIL reset_cycle_grants got=%b exp=0000", gs); end
    next_cycle();
    idle_in();
    @(negedge clk);
    checks++;
    if (gs !== 4'b0000) begin errors++; $display("FAIL reset_grant_stall got=%b exp=0000", gs); end
    checks++;
    if (dv !== 2'b00) begin errors++; $display("FAIL reset_valid got=%b exp=00", dv); end
    checks++;
    if ({mem_rd, mem_wr, err} !== 3'b000) begin
      errors++; $display("FAIL reset_mem_ctl got=%b exp=000", {mem_rd, mem_wr, err});
    end
    checks++;
    if ({mem_addr, mem_data_in} !== 32'h0) begin
      errors++; $display("FAIL reset_mem_bus got=%h exp=0", {mem_addr, mem_data_in});
    end
    checks++;
    if (data_out !== mem_data_out) begin
      errors++; $display("FAIL reset_data_out got=%h exp=%h", data_out, mem_data_out);
    end
    next_cycle();
  endtask

  task automatic test_single_read();
    idle_in();
    rd_1 = 1'b1; addr_1 = 16'h1234; data_in_1 = 16'h5555;
    @(negedge clk);
    checks++;
    if (gs !== 4'b0100) begin errors++; $display("FAIL single_grant got=%b exp=0100", gs); end
    checks++;
    if ({mem_rd, mem_wr, mem_addr} !== {1'b1, 1'b0, 16'h1234}) begin
      errors++; $display("FAIL single_mem got=%h exp=%h", {mem_rd, mem_wr, mem_addr}, {1'b1, 1'b0, 16'h1234});
    end
    next_cycle();
    for (int i = 1; i <= 3; i++) begin
      idle_in();
      @(negedge clk);
      checks++;
      if (dv !== ((i == 2) ? 2'b01 : 2'b00)) begin
        errors++; $display("FAIL single_valid cyc+%0d got=%b exp=%b", i, dv, (i == 2) ? 2'b01 : 2'b00);
      end
      if (i == 2) begin
        checks++;
        if (data_out !== mem_data_out) begin
          errors++; $display("FAIL single_data got=%h exp=%h", data_out, mem_data_out);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_contention();
    logic [3:0] exp_gs;
    logic [1:0] exp_dv;
    bit g0, g1;
    idle_in();
    rst = 1'b1;
    @(negedge clk);
    next_cycle();
    for (int i = 0; i <= 5; i++) begin
      idle_in();
      if (i < 3) begin
        rd_0 = 1'b1; addr_0 = 16'(16'h0100 + i);
        rd_1 = 1'b1; addr_1 = 16'(16'h0200 + i);
      end
      @(negedge clk);
      g0 = (i < 3) && (i % 2 == 0);
      g1 = (i < 3) && (i % 2 == 1);
      exp_gs = {g0, g1, (i < 3) && !g0, (i < 3) && !g1};
      exp_dv = {(i >= 2) && (i <= 4) && (i % 2 == 0), (i == 3)};
      checks++;
      if (gs !== exp_gs) begin errors++; $display("FAIL contend_grant i=%0d got=%b exp=%b", i, gs, exp_gs); end
      checks++;
      if (dv !== exp_dv) begin errors++; $display("FAIL contend_valid i=%0d got=%b exp=%b", i, dv, exp_dv); end
      if (i < 3) begin
        checks++;
        if (mem_addr !== (g0 ? addr_0 : addr_1)) begin
          errors++; $display("FAIL contend_addr i=%0d got=%h exp=%h", i, mem_addr, g0 ? addr_0 : addr_1);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_locked_burst();
    int n_dv1 = 0;
    logic [3:0] exp_gs;
    logic [1:0] exp_dv;
    idle_in();
    wr_0 = 1'b1; addr_0 = 16'h00F0; data_in_0 = 16'h0A0A;
    @(negedge clk);
    checks++;
    if (gs !== 4'b1000) begin errors++; $display("FAIL burst_pre_grant got=%b exp=1000", gs); end
    next_cycle();
    for (int i = 0; i <= 10; i++) begin
      idle_in();
      if (i <= 8) begin rd_0 = 1'b1; addr_0 = 16'h0500; end
      if (i < 8) begin
        lock_1 = (i < 7);
        if (i < 4) begin
          wr_1 = 1'b1; addr_1 = 16'(16'h2000 + 2 * i); data_in_1 = 16'(i);
        end else begin
          rd_1 = 1'b1; addr_1 = 16'(16'h3000 + 2 * (i - 4));
        end
      end
      @(negedge clk);
      exp_gs = {i == 8, i < 8, i < 8, 1'b0};
      exp_dv = {i == 10, (i >= 6) && (i <= 9)};
      checks++;
      if (gs !== exp_gs) begin errors++; $display("FAIL burst_grant i=%0d got=%b exp=%b", i, gs, exp_gs); end
      checks++;
      if (dv !== exp_dv) begin errors++; $display("FAIL burst_valid i=%0d got=%b exp=%b", i, dv, exp_dv); end
      if (i < 8) begin
        checks++;
        if ({mem_rd, mem_wr, mem_addr} !== {i >= 4, i < 4, addr_1}) begin
          errors++; $display("FAIL burst_mem i=%0d got=%h exp=%h", i, {mem_rd, mem_wr, mem_addr}, {i >= 4, i < 4, addr_1});
        end
      end
      if (data_valid_1 === 1'b1) n_dv1++;
      next_cycle();
    end
    checks++;
    if (n_dv1 != 4) begin errors++; $display("FAIL burst_return_count got=%0d exp=4", n_dv1); end
  endtask

  task automatic test_mem_stall();
    int k = 0;
    logic [3:0] exp_gs;
    logic [1:0] exp_dv;
    for (int i = 0; i <= 8; i++) begin
      idle_in();
      if (i <= 5) begin
        rd_0 = 1'b1; lock_0 = (i < 5); addr_0 = 16'(16'h4000 + 2 * k);
      end
      mem_stall = (i == 2) || (i == 3);
      @(negedge clk);
      exp_gs = {i <= 5, 1'b0, (i == 2) || (i == 3), 1'b0};
      exp_dv = {(i == 2) || (i == 3) || (i == 6) || (i == 7), 1'b0};
      checks++;
      if (gs !== exp_gs) begin errors++; $display("FAIL mstall_grant i=%0d got=%b exp=%b", i, gs, exp_gs); end
      checks++;
      if (dv !== exp_dv) begin errors++; $display("FAIL mstall_valid i=%0d got=%b exp=%b", i, dv, exp_dv); end
      if (i <= 5) begin
        checks++;
        if (mem_addr !== 16'(16'h4000 + 2 * k)) begin
          errors++; $display("FAIL mstall_addr i=%0d got=%h exp=%h", i, mem_addr, 16'(16'h4000 + 2 * k));
        end
        if (!mem_stall) k++;
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [3:0] exp_gs;
    logic [1:0] exp_dv;
    for (int i = 0; i <= 10; i++) begin
      idle_in();
      if (i < 3) begin lock_1 = 1'b1; rd_1 = 1'b1; addr_1 = 16'(16'h6000 + i); end
      if (i == 3) rst = 1'b1;
      if (i == 6) begin rd_0 = 1'b1; addr_0 = 16'h7000; rd_1 = 1'b1; addr_1 = 16'h7100; end
      if (i == 7) begin rd_1 = 1'b1; addr_1 = 16'h7100; end
      @(negedge clk);
      exp_gs = {i == 6, (i < 3) || (i == 7), 1'b0, i == 6};
      exp_dv = {i == 8, (i == 2) || (i == 9)};
      checks++;
      if (gs !== exp_gs) begin errors++; $display("FAIL rstmid_grant i=%0d got=%b exp=%b", i, gs, exp_gs); end
      if (i != 3) begin
        checks++;
        if (dv !== exp_dv) begin errors++; $display("FAIL rstmid_valid i=%0d got=%b exp=%b", i, dv, exp_dv); end
      end
      next_cycle();
    end
  endtask

  task automatic test_error();
    logic [3:0] exp_gs;
    logic [1:0] exp_dv;
    logic [2:0] exp_ctl;
    for (int i = 0; i <= 6; i++) begin
      idle_in();
      case (i)
        0: begin rd_0 = 1'b1; wr_0 = 1'b1; addr_0 = 16'h8000; end
        2: begin rd_1 = 1'b1; wr_1 = 1'b1; addr_1 = 16'h8100; end
        3: begin lock_0 = 1'b1; rd_1 = 1'b1; wr_1 = 1'b1; addr_1 = 16'h8200; end
        default: ;
      endcase
      @(negedge clk);
      case (i)
        0: begin exp_gs = 4'b1000; exp_ctl = 3'b111; end
        2: begin exp_gs = 4'b0100; exp_ctl = 3'b111; end
        3: begin exp_gs = 4'b1001; exp_ctl = 3'b000; end
        4: begin exp_gs = 4'b1000; exp_ctl = 3'b000; end
        default: begin exp_gs = 4'b0000; exp_ctl = 3'b000; end
      endcase
      exp_dv = (i == 2) ? 2'b10 : (i == 4) ? 2'b01 : 2'b00;
      checks++;
      if (gs !== exp_gs) begin errors++; $display("FAIL err_grant i=%0d got=%b exp=%b", i, gs, exp_gs); end
      checks++;
      if ({mem_rd, mem_wr, err} !== exp_ctl) begin
        errors++; $display("FAIL err_flag i=%0d got=%b exp=%b", i, {mem_rd, mem_wr, err}, exp_ctl);
      end
      checks++;
      if (dv !== exp_dv) begin errors++; $display("FAIL err_valid i=%0d got=%b exp=%b", i, dv, exp_dv); end
      next_cycle();
    end
  endtask

  task automatic test_random();
    int g;
    logic [6:0]   exp_ctl;
    logic [W-1:0] exp_addr, exp_din;
    logic [1:0]   exp_dv;
    bit           e_rd, e_wr;
    for (int n = 0; n < 600; n++) begin
      rst       = ($urandom % 100) == 0;
      mem_stall = ($urandom % 5) == 0;
      rd_0   = (($urandom % 3) != 0) && ($urandom % 2 == 0);
      wr_0   = ($urandom % 4) == 0;
      lock_0 = ($urandom % 3) == 0;
      rd_1   = (($urandom % 3) != 0) && ($urandom % 2 == 0);
      wr_1   = ($urandom % 4) == 0;
      lock_1 = ($urandom % 3) == 0;
      addr_0 = W'($urandom); data_in_0 = W'($urandom);
      addr_1 = W'($urandom); data_in_1 = W'($urandom);
      @(negedge clk);
      g = model_grant();
      e_rd     = (g == 0) ? rd_0 : (g == 1) ? rd_1 : 1'b0;
      e_wr     = (g == 0) ? wr_0 : (g == 1) ? wr_1 : 1'b0;
      exp_addr = (g == 0) ? addr_0 : (g == 1) ? addr_1 : '0;
      exp_din  = (g == 0) ? data_in_0 : (g == 1) ? data_in_1 : '0;
      exp_ctl  = {g == 0, g == 1, req(0) && ((g != 0) || mem_stall), req(1) && ((g != 1) || mem_stall),
                  e_rd, e_wr, e_rd && e_wr};
      exp_dv   = !ret_q.exists(cyc) ? 2'b00 : (ret_q[cyc] == 0) ? 2'b10 : 2'b01;
      checks++;
      if ({gs, mem_rd, mem_wr, err} !== exp_ctl) begin
        errors++; $display("FAIL rand_ctl n=%0d got=%b exp=%b", n, {gs, mem_rd, mem_wr, err}, exp_ctl);
      end
      checks++;
      if ({mem_addr, mem_data_in} !== {exp_addr, exp_din}) begin
        errors++; $display("FAIL rand_bus n=%0d got=%h exp=%h", n, {mem_addr, mem_data_in}, {exp_addr, exp_din});
      end
      checks++;
      if (data_out !== mem_data_out) begin
        errors++; $display("FAIL rand_data n=%0d got=%h exp=%h", n, data_out, mem_data_out);
      end
      if (!rst) begin
        checks++;
        if (dv !== exp_dv) begin errors++; $display("FAIL rand_valid n=%0d got=%b exp=%b", n, dv, exp_dv); end
      end
      next_cycle();
    end
  endtask

  initial begin
    mem_data_out = 16'h0;
    test_reset();
    test_single_read();
    test_contention();
    test_locked_burst();
    test_mem_stall();
    test_reset_mid_burst();
    test_error();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
